// File: rtl/hex_syscall_unit_pkg.sv
// Shared types for the Hex core syscall responder.
//   waddr_t      : 16-bit data-memory word address
//   data_t       : 32-bit data-memory word
//   syscall_t    : SVC opcode (EXIT/WRITE/READ; 3 is illegal)
//   svc_state_t  : responder FSM states
//   SP_WADDR_DEFAULT, SVC_ARG_OFFSET, SVC_RES_OFFSET : memory layout constants
package hex_syscall_unit_pkg;

  typedef logic [15:0] waddr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    EXIT  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } syscall_t;

  typedef enum logic [3:0] {
    IDLE, LD_SP, SP_W, LD_ARG, ARG_W, IO_OUT, IO_IN, ST_RES, DONE, HALTED
  } svc_state_t;

  localparam waddr_t SP_WADDR_DEFAULT = 16'd1;
  // Stack frame, relative to the stack pointer word address.
  localparam waddr_t SVC_ARG_OFFSET   = 16'd2;  // first argument
  localparam waddr_t SVC_RES_OFFSET   = 16'd1;  // syscall result slot

endpackage

// File: rtl/hex_syscall_unit.sv
// Hex core SVC responder. Fetches the stack pointer and argument from data
// memory, performs a single-byte stream write/read or halts, stores any
// result, then pulses svc_done to release the stalled core.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   svc_valid/svc_opcode/svc_done      syscall request from the core
//   mem_req/we/addr/wdata, gnt, rdata  shared data-memory port (rdata one
//                                      cycle after gnt)
//   out_valid/out_ready/out_data       output byte stream
//   in_valid/in_ready/in_data          input byte stream
//   halt, exit_code                    sticky program-exit status
//   error                              sticky illegal-syscall flag
module hex_syscall_unit
  import hex_syscall_unit_pkg::*;
#(
  parameter waddr_t SP_WADDR = SP_WADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        svc_valid,
  input  logic [1:0]  svc_opcode,
  output logic        svc_done,
  output logic        mem_req,
  output logic        mem_we,
  output waddr_t      mem_addr,
  output data_t       mem_wdata,
  input  logic        mem_gnt,
  input  data_t       mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        halt,
  output data_t       exit_code,
  output logic        error
);

  svc_state_t r_state, w_next;
  syscall_t   r_op;
  waddr_t     r_sp;
  data_t      r_arg;
  logic [7:0] r_byte;
  logic       r_error;

  logic w_accept, w_illegal;
  assign w_accept  = (r_state == IDLE) && svc_valid;
  assign w_illegal = (svc_opcode == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Operand capture. The opcode is latched once at acceptance so the core
  // may change svc_opcode freely while the syscall is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op    <= EXIT;
      r_sp    <= '0;
      r_arg   <= '0;
      r_byte  <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= syscall_t'(svc_opcode);
        if (w_illegal) r_error <= 1'b1;
      end
      // Read data arrives the cycle after the grant, i.e. in the *_W states.
      if (r_state == SP_W)              r_sp   <= mem_rdata[15:0];
      if (r_state == ARG_W)             r_arg  <= mem_rdata;
      if (r_state == IO_IN && in_valid) r_byte <= in_data;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (svc_valid) w_next = w_illegal ? DONE : LD_SP;
      LD_SP:   if (mem_gnt)   w_next = SP_W;
      SP_W:    w_next = (r_op == READ) ? IO_IN : LD_ARG;
      LD_ARG:  if (mem_gnt)   w_next = ARG_W;
      ARG_W:   w_next = (r_op == WRITE) ? IO_OUT : HALTED;
      IO_OUT:  if (out_ready) w_next = DONE;
      IO_IN:   if (in_valid)  w_next = ST_RES;
      ST_RES:  if (mem_gnt)   w_next = DONE;
      DONE:    w_next = IDLE;
      HALTED:  w_next = HALTED;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are pure functions of state and captured operands, so the
  // request/stream signals stay stable for as long as a state is held and
  // every output returns to zero the edge after reset.
  always_comb begin
    svc_done  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    out_valid = 1'b0;
    out_data  = '0;
    in_ready  = 1'b0;
    halt      = 1'b0;
    exit_code = '0;
    case (r_state)
      LD_SP: begin
        mem_req  = 1'b1;
        mem_addr = SP_WADDR;
      end
      LD_ARG: begin
        mem_req  = 1'b1;
        mem_addr = r_sp + SVC_ARG_OFFSET;  // wraps modulo 2^16
      end
      ST_RES: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_sp + SVC_RES_OFFSET; // wraps modulo 2^16
        mem_wdata = {24'b0, r_byte};
      end
      IO_OUT: begin
        out_valid = 1'b1;
        out_data  = r_arg[7:0];
      end
      IO_IN:  in_ready = 1'b1;
      DONE:   svc_done = 1'b1;
      HALTED: begin
        halt      = 1'b1;
        exit_code = r_arg;
      end
      default: ;
    endcase
  end

  assign error = r_error;

endmodule

// File: tb/tb_hex_syscall_unit.sv
module tb_hex_syscall_unit;

  localparam logic [15:0] SP = 16'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        svc_valid = 1'b0;
  logic [1:0]  svc_opcode = 2'd0;
  logic        svc_done;
  logic        mem_req, mem_we, mem_gnt;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        in_valid, in_ready;
  logic [7:0]  in_data = 8'h0;
  logic        halt, error;
  logic [31:0] exit_code;

  always #5 clk = ~clk;

  hex_syscall_unit dut (
    .clk(clk), .rst_n(rst_n),
    .svc_valid(svc_valid), .svc_opcode(svc_opcode), .svc_done(svc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .halt(halt), .exit_code(exit_code), .error(error)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        got_log[$];
  acc_t        exp_log[$];
  logic [31:0] mem [0:65535];

  int cyc = 0, t0 = 0, n_chk = 0, n_err = 0;
  int cfg_g = 0, cfg_o = 0, cfg_i = 0;
  int gcnt = 0, ocnt = 0, icnt = 0;
  bit active = 0, err_sticky = 0;

  // Expectations for the syscall in flight (times relative to acceptance)
  logic [1:0]  exp_op = 2'd0;
  int          exp_done = -1, exp_halt = -1, ov_start = 0, ir_start = 0, ir_end = 0;
  logic [7:0]  exp_byte = 8'h0;
  logic [31:0] exp_arg = 32'h0;
  logic [7:0]  last_out = 8'h0;

  bit          prev_stall = 0;
  logic        prev_we = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [31:0] prev_wdata = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc - t0);
    end
  endtask

  // Environment: grant/ready/valid each withheld for a configured number of cycles
  always_comb mem_gnt   = mem_req   && (gcnt >= cfg_g);
  always_comb out_ready = out_valid && (ocnt >= cfg_o);
  always_comb in_valid  = in_ready  && (icnt >= cfg_i);

  always @(posedge clk) begin
    acc_t a;
    cyc  <= cyc + 1;
    gcnt <= (mem_req   && !mem_gnt)   ? gcnt + 1 : 0;
    ocnt <= (out_valid && !out_ready) ? ocnt + 1 : 0;
    icnt <= (in_ready  && !in_valid)  ? icnt + 1 : 0;
    if (mem_req && mem_gnt) begin
      a.we    = mem_we;
      a.addr  = mem_addr;
      a.wdata = mem_we ? mem_wdata : 32'h0;
      got_log.push_back(a);
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
    if (out_valid && out_ready) last_out <= out_data;
  end

  // Per-cycle comparison against the expectations
  always @(negedge clk) begin : cmp
    int t;
    t = cyc - t0;
    if (active) begin
      chk("svc_done", {31'b0, svc_done}, {31'b0, (exp_done >= 0 && t == exp_done)});
      chk("out_valid", {31'b0, out_valid},
          {31'b0, (exp_op == 2'd1 && t >= ov_start && t < exp_done)});
      if (out_valid) chk("out_data", {24'b0, out_data}, {24'b0, exp_byte});
      chk("in_ready", {31'b0, in_ready},
          {31'b0, (exp_op == 2'd2 && t >= ir_start && t <= ir_end)});
      chk("halt", {31'b0, halt}, {31'b0, (exp_op == 2'd0 && t >= exp_halt)});
      if (exp_op == 2'd0 && t >= exp_halt) begin
        chk("exit_code", exit_code, exp_arg);
        chk("halted_mem_req", {31'b0, mem_req}, 32'd0);
      end
      chk("error", {31'b0, error}, {31'b0, (err_sticky || (exp_op == 2'd3 && t >= 1))});
      if (prev_stall) begin
        chk("stall_req",   {31'b0, mem_req}, 32'd1);
        chk("stall_we",    {31'b0, mem_we},  {31'b0, prev_we});
        chk("stall_addr",  {16'b0, mem_addr}, {16'b0, prev_addr});
        chk("stall_wdata", mem_wdata, prev_wdata);
      end
    end
    prev_stall = mem_req && !mem_gnt;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  // Issue one syscall; the model predicts latency, stream byte and the exact
  // list of memory accesses from the memory image and the stall settings.
  task automatic run_svc(input logic [1:0] op, input int g, input int o, input int i,
                         input logic [7:0] ib, output int done_t);
    logic [15:0] sp;
    acc_t e;
    sp       = mem[SP][15:0];
    exp_arg  = mem[sp + 16'd2];
    exp_byte = exp_arg[7:0];
    cfg_g = g; cfg_o = o; cfg_i = i; in_data = ib;
    exp_op = op; exp_done = -1; exp_halt = -1;
    exp_log.delete(); got_log.delete(); done_t = -1;
    e.we = 1'b0; e.addr = SP; e.wdata = 32'h0;
    case (op)
      2'd0: begin
        exp_halt = 5 + 2 * g;
        exp_log.push_back(e);
        e.addr = sp + 16'd2; exp_log.push_back(e);
      end
      2'd1: begin
        exp_done = 6 + 2 * g + o; ov_start = 5 + 2 * g;
        exp_log.push_back(e);
        e.addr = sp + 16'd2; exp_log.push_back(e);
      end
      2'd2: begin
        exp_done = 5 + 2 * g + i; ir_start = 3 + g; ir_end = 3 + g + i;
        exp_log.push_back(e);
        e.we = 1'b1; e.addr = sp + 16'd1; e.wdata = {24'h0, ib}; exp_log.push_back(e);
      end
      default: exp_done = 1;
    endcase
    @(posedge clk); #1;
    t0 = cyc; svc_valid = 1'b1; svc_opcode = op; active = 1;
    @(posedge clk); #1;
    svc_opcode = ~op;  // must be ignored while busy
    if (op == 2'd0) begin
      repeat (25) @(posedge clk);
      #1;
    end else begin
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (svc_done) begin
          done_t = cyc - t0;
          break;
        end
      end
      if (done_t < 0) chk("svc_done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      svc_valid = 1'b0; svc_opcode = 2'd0;
      @(negedge clk);
      @(posedge clk); #1;
      active = 0;
      if (op == 2'd3) err_sticky = 1;
    end
    chk("acc_count", got_log.size(), exp_log.size());
    foreach (exp_log[k]) if (k < got_log.size()) begin
      chk("acc_we",    {31'b0, got_log[k].we},   {31'b0, exp_log[k].we});
      chk("acc_addr",  {16'b0, got_log[k].addr}, {16'b0, exp_log[k].addr});
      chk("acc_wdata", got_log[k].wdata, exp_log[k].wdata);
    end
  endtask

  initial begin
    int d;
    for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_svc_done",  {31'b0, svc_done},  32'd0);
    chk("rst_mem_req",   {31'b0, mem_req},   32'd0);
    chk("rst_mem_we",    {31'b0, mem_we},    32'd0);
    chk("rst_mem_addr",  {16'b0, mem_addr},  32'd0);
    chk("rst_mem_wdata", mem_wdata,          32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'b0, out_data},  32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
    chk("rst_halt",      {31'b0, halt},      32'd0);
    chk("rst_exit_code", exit_code,          32'd0);
    chk("rst_error",     {31'b0, error},     32'd0);
    rst_n = 1'b1;

    // WRITE, all ready
    mem[1] = 32'h0000_0100; mem[16'h0102] = 32'h0000_0041;
    run_svc(2'd1, 0, 0, 0, 8'h00, d);
    chk("wr_done_lit", d, 32'd6);
    chk("wr_byte_lit", {24'b0, last_out}, 32'h41);
    chk("wr_addr0_lit", {16'b0, got_log[0].addr}, 32'h1);
    chk("wr_addr1_lit", {16'b0, got_log[1].addr}, 32'h0102);

    // READ with in_valid delayed 3 cycles
    mem[1] = 32'h0000_0200;
    run_svc(2'd2, 0, 0, 3, 8'h5A, d);
    chk("rd_done_lit", d, 32'd8);
    chk("rd_mem_lit", mem[16'h0201], 32'h0000_005A);

    // WRITE with 2-cycle grant stalls and 4-cycle out_ready stall
    mem[1] = 32'h0000_0100; mem[16'h0102] = 32'h1234_5677;
    run_svc(2'd1, 2, 4, 0, 8'h00, d);
    chk("wr_stall_done_lit", d, 32'd14);
    chk("wr_stall_byte_lit", {24'b0, last_out}, 32'h77);

    // Illegal opcode
    run_svc(2'd3, 0, 0, 0, 8'h00, d);
    chk("ill_done_lit", d, 32'd1);
    chk("ill_error_lit", {31'b0, error}, 32'd1);
    chk("ill_no_mem_lit", got_log.size(), 32'd0);

    // READ with SP=0xFFFF: result slot wraps to word 0
    mem[1] = 32'h0000_FFFF; mem[0] = 32'hDEAD_BEEF;
    run_svc(2'd2, 1, 0, 0, 8'hC3, d);
    chk("wrap_done_lit", d, 32'd7);
    chk("wrap_mem_lit", mem[0], 32'h0000_00C3);

    // Reset while waiting in IO_OUT
    mem[1] = 32'h0000_0100; mem[16'h0102] = 32'h0000_0041;
    cfg_g = 0; cfg_o = 1000; cfg_i = 0;
    exp_op = 2'd1; exp_byte = 8'h41; exp_done = 1 << 30; ov_start = 5; exp_halt = -1;
    got_log.delete();
    @(posedge clk); #1;
    t0 = cyc; svc_valid = 1'b1; svc_opcode = 2'd1; active = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_pre_ov", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0; svc_valid = 1'b0; active = 0;
    @(posedge clk); #1;
    chk("rst_mid_ov",    {31'b0, out_valid}, 32'd0);
    chk("rst_mid_od",    {24'b0, out_data},  32'd0);
    chk("rst_mid_req",   {31'b0, mem_req},   32'd0);
    chk("rst_mid_done",  {31'b0, svc_done},  32'd0);
    chk("rst_mid_error", {31'b0, error},     32'd0);
    err_sticky = 0;
    rst_n = 1'b1;
    run_svc(2'd1, 0, 0, 0, 8'h00, d);
    chk("post_rst_done_lit", d, 32'd6);

    // EXIT, then a further request that must be ignored
    mem[1] = 32'h0000_0300; mem[16'h0302] = 32'h0000_0007;
    run_svc(2'd0, 0, 0, 0, 8'h00, d);
    chk("exit_code_lit", exit_code, 32'd7);
    chk("exit_halt_lit", {31'b0, halt}, 32'd1);
    svc_opcode = 2'd1;
    repeat (6) @(posedge clk);
    #1;
    active = 0;
    chk("exit_ignored_acc", got_log.size(), 32'd2);
    chk("exit_still_halt", {31'b0, halt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hex_syscall_unit.md
# hex_syscall_unit

Responder for the Hex core's `SVC` instruction. When the core executes `OPR SVC`, it presents the syscall number and stalls. This block then reads the stack pointer and arguments from data memory, performs the byte-stream I/O or halt, writes any result back to memory, and releases the core. It sits beside the core and shares the data memory through a request/grant port.

## Interface
- `SP_WADDR`, default 1: word address holding the stack pointer, which is itself a word address.
- `clk  in  1`: single clock.
- `rst_n  in  1`: reset, synchronous, active-low.
- `svc_valid  in  1`: syscall request; held high by the core until `svc_done`.
- `svc_opcode  in  2`: `syscall_t` (`EXIT`=0, `WRITE`=1, `READ`=2; 3 is illegal).
- `svc_done  out  1`: one-cycle pulse; the core resumes.
- `mem_req  out  1`: memory access request; held until `mem_gnt`.
- `mem_we  out  1`: 1 = write.
- `mem_addr  out  16`: `waddr_t` word address.
- `mem_wdata  out  32`: `data_t` write data.
- `mem_gnt  in  1`: access accepted this cycle.
- `mem_rdata  in  32`: read data, valid the cycle after `mem_gnt`.
- `out_valid  out  1`, `out_ready  in  1`, `out_data  out  8`: output byte stream.
- `in_valid  in  1`, `in_ready  out  1`, `in_data  in  8`: input byte stream.
- `halt  out  1`: sticky; the program has exited.
- `exit_code  out  32`: valid while `halt` is high.
- `error  out  1`: sticky; an illegal syscall was seen.

## Operation
- State machine states: `IDLE`, `LD_SP`, `SP_W`, `LD_ARG`, `ARG_W`, `IO_OUT`, `IO_IN`, `ST_RES`, `DONE`, `HALTED`.
- `IDLE`: samples `svc_valid`. Valid opcodes go to `LD_SP`. Opcode 3 sets `error` and goes to `DONE`.
- `LD_SP`: reads `SP_WADDR`. On `mem_gnt` go to `SP_W`, which captures `sp`.
- After `SP_W`:
  - `WRITE` and `EXIT` go to `LD_ARG`, which reads `sp+2`; `ARG_W` then captures `arg`.
  - `READ` goes to `IO_IN`.
- After `ARG_W`: `WRITE` goes to `IO_OUT`, `EXIT` goes to `HALTED`.
- `IO_OUT`: `out_valid`=1 with `out_data`=`arg[7:0]`. On `out_ready` go to `DONE`.
- `IO_IN`: `in_ready`=1. On `in_valid`, latch `in_data` and go to `ST_RES`.
- `ST_RES`: writes `{24'b0, byte}` to `sp+1`. On `mem_gnt` go to `DONE`.
- `DONE`: `svc_done`=1, then `IDLE`.
- `HALTED`: `halt`=1 and `exit_code`=`arg`. The state is terminal until reset, and `svc_done` is never pulsed.
- The stream-number argument (`sp+3` for `WRITE`, `sp+2` for `READ`) is not fetched; a single stream is supported.
- Address arithmetic is 16-bit modulo 2^16: `sp+1` and `sp+2` wrap.
- Handshake obligations:
  - The core drops `svc_valid` in the cycle after `svc_done`.
  - While busy, `svc_opcode` is latched at acceptance and later changes are ignored.
- The memory port holds `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stable until `mem_gnt`.
- `out_valid` is held with stable `out_data` until `out_ready`.

## Timing
- Reset values:
  - State is `IDLE`.
  - `svc_done`, `mem_req`, `mem_we`, `out_valid`, `in_ready`, `halt` and `error` are all 0.
  - `mem_addr`, `mem_wdata`, `out_data` and `exit_code` are 0.
- Reset mid-operation: all outputs reach their reset values at the next edge. A pending memory write is abandoned.
- Latencies count from acceptance in cycle 0, with `mem_gnt`, `out_ready` and `in_valid` all held high:
  - `WRITE`: `svc_done` in cycle 6, with `out_valid` in cycle 5.
  - `READ`: `svc_done` in cycle 5.
  - `EXIT`: `halt` rises in cycle 5.
  - Illegal opcode: `svc_done` in cycle 1.
- Each cycle of `mem_gnt`=0, `out_ready`=0 or `in_valid`=0 adds exactly one cycle.
- At most one memory access is outstanding at any time.

## Structure
- Add to the shared package:
  - the FSM state enum `svc_state_t`;
  - `SP_WADDR_DEFAULT`;
  - `SVC_ARG_OFFSET`=2 and `SVC_RES_OFFSET`=1;
  - `syscall_t` is already there.
- Single module. No sub-module is natural, because the memory sequencing is part of the FSM. Target size is 150–250 lines.

## Test plan
- `WRITE` with mem[1]=0x0100 and mem[0x0102]=0x00000041, all ready:
  - reads issue to 1 and then 0x0102;
  - `out_data`=0x41 in cycle 5;
  - `svc_done` in cycle 6.
- `READ` with mem[1]=0x0200 and `in_data`=0x5A after a 3-cycle `in_valid` delay:
  - mem[0x0201]=0x0000005A;
  - `svc_done` in cycle 8.
- `EXIT` with mem[0x0302]=7:
  - `halt`=1 and `exit_code`=7 hold for 20 cycles;
  - no `svc_done`;
  - a further `svc_valid` is ignored.
- `WRITE` with `mem_gnt` stalled 2 cycles per access and `out_ready` stalled 4 cycles:
  - `svc_done` in cycle 14;
  - request signals stay stable throughout the stalls.
- Opcode 3: `error`=1 and `svc_done` in cycle 1, with no memory access. Also SP=0xFFFF under `READ`: the result is written to word 0x0000.
- `rst_n` low during `IO_OUT`:
  - `out_valid`=0 at the next edge;
  - state returns to `IDLE`;
  - a subsequent `WRITE` completes normally.
